// File: rtl/intrusion_zone_annunciator.sv
// Receive end of the intrusion-zone encoder link: debounce, sticky per-zone latches,
// alarm/silence FSM, blink strobe and display scanner. Optional ZONE_MASK_EN adds zone_mask.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no zone latched, panel dark
// ALARM    | at least one latch set, blink running
// SILENCED | latches still set, operator silenced the blink
module intrusion_zone_annunciator #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int SCAN_DWELL      = 4,
   parameter int BLINK_DIV       = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] intrusion_zone,
   input  logic       valid,
   input  logic       ack,
   input  logic [2:0] ack_zone,
   input  logic       silence,
`ifdef ZONE_MASK_EN
   input  logic [1:8] zone_mask,
`endif
   output logic [1:8] zone,
   output logic       alarm,
   output logic       blink,
   output logic [2:0] display_zone,
   output logic       display_valid
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam int BK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DWELL - 1);
   localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);
   localparam logic [BK_W-1:0] BK_LAST = BK_W'(BLINK_DIV - 1);
   localparam logic [BK_W-1:0] BK_ONE  = BK_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ALARM    = 2'd1,
      ST_SILENCED = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        in_idx_q, in_idx_d;
   logic              in_vld_q, in_vld_d;
   logic [2:0]        last_idx_q, last_idx_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [7:0]        latch_q, latch_d;
   logic              blink_q, blink_d;
   logic [BK_W-1:0]   bk_cnt_q, bk_cnt_d;
   logic [2:0]        disp_zone_q, disp_zone_d;
   logic              disp_vld_q, disp_vld_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;

   logic [7:0]        allow_mask;
   logic [7:0]        set_mask;
   logic [7:0]        ack_mask;
   logic              new_set;

   // First latched index strictly after cur, wrapping; returns cur itself if it is the only one.
   function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
      logic [2:0] r;
      logic       found;
      logic [2:0] c;
      r     = cur;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         c = cur + 3'(k);
         if (!found && m[c]) begin
            r     = c;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      allow_mask = '1;
`ifdef ZONE_MASK_EN
      for (int i = 0; i < 8; i++) begin
         allow_mask[i] = ~zone_mask[i+1];
      end
`endif
   end

   always_comb begin
      in_idx_d   = intrusion_zone;
      in_vld_d   = valid;
      last_idx_d = in_idx_q;

      db_cnt_d = '0;
      if (in_vld_q) begin
         if (in_idx_q != last_idx_q) begin
            db_cnt_d = DB_ONE;
         end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + DB_ONE;
         end else begin
            db_cnt_d = db_cnt_q;
         end
      end

      set_mask = '0;
      if (in_vld_q && (db_cnt_d == DB_MAX)) begin
         set_mask = 8'd1 << in_idx_q;
      end
      set_mask = set_mask & allow_mask;

      ack_mask = '0;
      if (ack) begin
         ack_mask = 8'd1 << ack_zone;
      end

      // a set on the same edge as its ack wins
      latch_d = (latch_q & ~ack_mask) | set_mask;
      new_set = |(set_mask & ~latch_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (latch_d != 8'd0) state_d = ST_ALARM;
         end
         ST_ALARM: begin
            if (latch_d == 8'd0)  state_d = ST_IDLE;
            else if (silence)     state_d = ST_SILENCED;
         end
         ST_SILENCED: begin
            if (latch_d == 8'd0)  state_d = ST_IDLE;
            else if (new_set)     state_d = ST_ALARM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      blink_d  = 1'b0;
      bk_cnt_d = '0;
      if (state_d == ST_ALARM) begin
         if (state_q != ST_ALARM) begin
            blink_d  = 1'b1;
            bk_cnt_d = '0;
         end else if (bk_cnt_q == BK_LAST) begin
            blink_d  = ~blink_q;
            bk_cnt_d = '0;
         end else begin
            blink_d  = blink_q;
            bk_cnt_d = bk_cnt_q + BK_ONE;
         end
      end
   end

   always_comb begin
      disp_zone_d = disp_zone_q;
      dwell_d     = dwell_q;
      disp_vld_d  = (latch_d != 8'd0);
      if (latch_d == 8'd0) begin
         disp_zone_d = '0;
         dwell_d     = '0;
      end else if (!disp_vld_q) begin
         disp_zone_d = next_set(latch_d, 3'd7);
         dwell_d     = '0;
      end else if (!latch_d[disp_zone_q] || (dwell_q == DW_LAST)) begin
         disp_zone_d = next_set(latch_d, disp_zone_q);
         dwell_d     = '0;
      end else begin
         dwell_d     = dwell_q + DW_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_idx_q    <= '0;
         in_vld_q    <= 1'b0;
         last_idx_q  <= '0;
         db_cnt_q    <= '0;
         latch_q     <= '0;
         blink_q     <= 1'b0;
         bk_cnt_q    <= '0;
         disp_zone_q <= '0;
         disp_vld_q  <= 1'b0;
         dwell_q     <= '0;
      end else begin
         state_q     <= state_d;
         in_idx_q    <= in_idx_d;
         in_vld_q    <= in_vld_d;
         last_idx_q  <= last_idx_d;
         db_cnt_q    <= db_cnt_d;
         latch_q     <= latch_d;
         blink_q     <= blink_d;
         bk_cnt_q    <= bk_cnt_d;
         disp_zone_q <= disp_zone_d;
         disp_vld_q  <= disp_vld_d;
         dwell_q     <= dwell_d;
      end
   end

   always_comb begin
      zone = '0;
      for (int k = 0; k < 8; k++) begin
         zone[k+1] = latch_q[k];
      end
      alarm         = (state_q != ST_IDLE);
      blink         = blink_q;
      display_zone  = disp_zone_q;
      display_valid = disp_vld_q;
   end

endmodule
